fft32_stage_sched: RTL
======================

// Module: fft32_stage_sched
// PURPOSE
//  Sequencer for the 32-point radix-2 FFT array: 16 MAC butterfly rows, 5 stages.
//  - Accepts a frame start with a valid/ready handshake.
//  - Steps the shared butterfly array through its stages: drives sel_line, twiddle stage index, register enable.
//  - Holds the result until the consumer takes it, then counts completed frames.
// PARAMETERS
//  N_STAGES      5   number of butterfly stages (log2 of FFT size)
//  SEL_W         3   width of sel_line / tw_stage; must satisfy 2**SEL_W >= N_STAGES
//  STAGE_CYCLES  2   cycles per stage, for MAC settle/pipeline; legal range 1..15
//  CNT_W         8   width of frame_cnt
// PORTS
//  clk         in   1      system clock; the only clock
//  rst         in   1      synchronous reset, active-high
//  start       in   1      frame request; Xn_* inputs are stable while start=1
//  in_ready    out  1      scheduler can accept a frame
//  sel_line    out  SEL_W  butterfly input-mux select = current stage (0..N_STAGES-1)
//  tw_stage    out  SEL_W  twiddle-ROM stage index; equals sel_line
//  stage_en    out  1      one-cycle commit strobe for the row output registers
//  busy        out  1      frame in flight (RUN state)
//  out_valid   out  1      Xw_out_* hold a complete frame
//  out_ready   in   1      consumer accepts the frame
//  frame_cnt   out  CNT_W  completed-frame count
//  abort       in   1      only present when FFT_SCHED_ABORT_EN is defined
// BEHAVIOUR
//  - Moore FSM with states IDLE, RUN, DONE. Outputs decode from registered state, stage and cycle counter.
//  - Reset: on the rst edge, state=IDLE, stage=0, cyc=0, frame_cnt=0.
//    Output values: sel_line=0, tw_stage=0, stage_en=0, busy=0, out_valid=0, in_ready=1.
//    A rst asserted mid-frame drops the frame with no out_valid and no count.
//  - IDLE: in_ready=1. Acceptance = start & in_ready at a clk edge; next state RUN, stage=0, cyc=0.
//    start while not IDLE is ignored and is not queued.
//  - RUN: busy=1, in_ready=0, sel_line=tw_stage=stage.
//    - cyc counts 0..STAGE_CYCLES-1; stage_en=1 only when cyc==STAGE_CYCLES-1.
//    - On that cycle: if stage<N_STAGES-1, then stage+1 and cyc=0; else next state DONE.
//    - Stage 0 selects the raw Xn inputs (sample_x_0 path).
//  - DONE: out_valid=1, busy=0, in_ready=0, stage_en=0. sel_line holds N_STAGES-1.
//    - out_valid stays high until out_ready=1. On that edge: next state IDLE and frame_cnt+1.
//    - frame_cnt wraps from 2**CNT_W-1 to 0.
//    - No new frame is accepted in the same cycle as the handshake; the earliest acceptance is the next cycle.
//  - Timing: acceptance edge = cycle 0. RUN occupies cycles 1..N_STAGES*STAGE_CYCLES.
//    stage_en fires at cycles k*STAGE_CYCLES, k=1..N_STAGES. out_valid first at N_STAGES*STAGE_CYCLES+1.
//  - Back-to-back throughput: one frame per N_STAGES*STAGE_CYCLES+2 cycles when out_ready is tied high.
//  - out_ready while not in DONE has no effect.
// CONFIGURATION
//  - FFT_SCHED_ABORT_EN defined:
//    - Adds input abort. abort=1 in RUN or DONE forces IDLE on the next edge.
//    - stage_en is suppressed in that cycle; frame_cnt does not increment, even if out_ready=1 in the same cycle.
//    - rst has priority over abort. abort in IDLE is ignored and does not block start.
//  - Not defined: no abort port; a frame runs to DONE unless rst is asserted.
// TESTING
//  1. Reset, then start=1 for 1 cycle, out_ready=1 (defaults):
//     stage_en at cycles 2,4,6,8,10 with sel_line 0,1,2,3,4; out_valid at cycle 11; frame_cnt=1 at 12.
//  2. STAGE_CYCLES=1, out_ready=0 until cycle 20:
//     out_valid high cycles 6..20; in_ready=0 throughout; IDLE at 21; start at 20 ignored, start at 21 accepted.
//  3. start held high permanently, out_ready=1:
//     accepted every 12 cycles; frame_cnt 0->1->2->3 after 36 cycles; no stage_en while in DONE.
//  4. rst=1 at cycle 5 of a frame:
//     next cycle sel_line=0, busy=0, out_valid=0, frame_cnt unchanged=0; a new start then completes normally.
//  5. CNT_W=2, 5 frames: frame_cnt sequence 1,2,3,0,1.
//  6. FFT_SCHED_ABORT_EN, abort at cycle 6:
//     IDLE at 7, no stage_en at 6, frame_cnt unchanged. Abort in DONE with out_ready=1 gives no increment.

Source files
------------

// File: rtl/fft32_stage_sched.sv
// fft32_stage_sched: stage sequencer for the 16-row radix-2 MAC butterfly array of a 32-point FFT.
// Define FFT_SCHED_ABORT_EN to add the abort input that cancels a frame in RUN or DONE.
module fft32_stage_sched #(
    parameter int N_STAGES     = 5,
    parameter int SEL_W        = 3,
    parameter int STAGE_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel_line,
    output logic [SEL_W-1:0] tw_stage,
    output logic             stage_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_cnt
`ifdef FFT_SCHED_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int CYC_W = 4;
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(STAGE_CYCLES - 1);
    // Value of cyc one cycle before the commit cycle; unreachable when STAGE_CYCLES is 1.
    localparam logic [CYC_W-1:0] CYC_PRE    = CYC_W'(STAGE_CYCLES - 2);
    localparam logic [SEL_W-1:0] STAGE_LAST = SEL_W'(N_STAGES - 1);
    localparam logic             EN_ON_ZERO = (STAGE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] stage;
    logic [CYC_W-1:0] cyc;
    logic             stage_en_q;

    // Outputs are registered alongside the state: each branch loads the values of the state it enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stage      <= '0;
            cyc        <= '0;
            frame_cnt  <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            stage_en_q <= 1'b0;
        end else begin
            stage_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        stage      <= '0;
                        cyc        <= '0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        stage_en_q <= EN_ON_ZERO;
                    end
                end
                RUN: begin
                    if (cyc == CYC_LAST) begin
                        cyc <= '0;
                        if (stage == STAGE_LAST) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            stage      <= stage + 1'b1;
                            stage_en_q <= EN_ON_ZERO;
                        end
                    end else begin
                        cyc        <= cyc + 1'b1;
                        stage_en_q <= (cyc == CYC_PRE);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        stage     <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    stage     <= '0;
                    cyc       <= '0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
`ifdef FFT_SCHED_ABORT_EN
            // Abort overrides every transition above, including a same-cycle DONE handshake.
            if (abort && (state != IDLE)) begin
                state      <= IDLE;
                stage      <= '0;
                cyc        <= '0;
                in_ready   <= 1'b1;
                busy       <= 1'b0;
                out_valid  <= 1'b0;
                stage_en_q <= 1'b0;
                frame_cnt  <= frame_cnt;
            end
`endif
        end
    end

    assign sel_line = stage;
    assign tw_stage = stage;

`ifdef FFT_SCHED_ABORT_EN
    assign stage_en = stage_en_q & ~abort;
`else
    assign stage_en = stage_en_q;
`endif

endmodule
